// File: rtl/poly_eval.sv
// rtl/poly_eval.sv - pipelined quadratic evaluator y_hat = b0 + b1*xi + b2*xi*xi
module poly_eval #(
  parameter int N_SAMPLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               coef_load,
  input  logic signed [23:0] b0,
  input  logic signed [23:0] b1,
  input  logic signed [23:0] b2,
  input  logic               in_valid,
  input  logic [11:0]        xi,
  output logic               in_ready,
  output logic               y_valid,
  input  logic               y_ready,
  output logic signed [49:0] y_hat,
  output logic [9:0]         y_idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [10:0] N_CNT    = 11'(N_SAMPLES);
  localparam logic [10:0] LAST_CNT = 11'(N_SAMPLES - 1);
  localparam logic [9:0]  LAST_IDX = 10'(N_SAMPLES - 1);

  state_t             state;
  logic signed [23:0] b0_r;
  logic signed [23:0] b1_r;
  logic signed [23:0] b2_r;
  logic [10:0]        cnt;

  logic               s1_v;
  logic [23:0]        s1_xx;
  logic signed [36:0] s1_b1x;
  logic [9:0]         s1_idx;

  logic               s2_v;
  logic signed [49:0] s2_a;
  logic signed [48:0] s2_c;
  logic [9:0]         s2_idx;

  logic               advance;
  logic               accept;
  logic               take;

  logic [23:0]        xx_d;
  logic signed [36:0] b1x_d;
  logic signed [48:0] b2xx_d;
  logic signed [49:0] a_d;
  logic signed [49:0] sum_d;

  // Every stage moves together; a full output register blocked by y_ready freezes all of them.
  assign advance  = !y_valid || y_ready;
  assign in_ready = (state == RUN) && (cnt < N_CNT) && advance;
  assign accept   = in_valid && in_ready;
  assign take     = y_valid && y_ready;

  // Products are sized so that no operand combination can overflow.
  assign xx_d   = 24'(xi) * 24'(xi);
  assign b1x_d  = 37'(b1_r) * 37'($signed({1'b0, xi}));
  assign b2xx_d = 49'(b2_r) * 49'($signed({1'b0, s1_xx}));
  assign a_d    = 50'(b0_r) + 50'(s1_b1x);
  assign sum_d  = s2_a + 50'(s2_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      b0_r  <= '0;
      b1_r  <= '0;
      b2_r  <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (coef_load) begin
            b0_r  <= b0;
            b1_r  <= b1;
            b2_r  <= b2;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            cnt <= cnt + 11'd1;
            if (cnt == LAST_CNT) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (take && (y_idx == LAST_IDX)) begin
            done  <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_xx   <= '0;
      s1_b1x  <= '0;
      s1_idx  <= '0;
      s2_v    <= 1'b0;
      s2_a    <= '0;
      s2_c    <= '0;
      s2_idx  <= '0;
      y_valid <= 1'b0;
      y_hat   <= '0;
      y_idx   <= '0;
    end else if (advance) begin
      s1_v <= accept;
      if (accept) begin
        s1_xx  <= xx_d;
        s1_b1x <= b1x_d;
        s1_idx <= cnt[9:0];
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_a   <= a_d;
        s2_c   <= b2xx_d;
        s2_idx <= s1_idx;
      end
      y_valid <= s2_v;
      if (s2_v) begin
        y_hat <= sum_d;
        y_idx <= s2_idx;
      end
    end
  end

endmodule

// File: tb/tb_poly_eval.sv
// tb/tb_poly_eval.sv - directed vector bench for poly_eval
module tb_poly_eval;

  localparam int N = 1024;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               coef_load = 1'b0;
  logic signed [23:0] b0 = '0;
  logic signed [23:0] b1 = '0;
  logic signed [23:0] b2 = '0;
  logic               in_valid = 1'b0;
  logic [11:0]        xi = '0;
  logic               y_ready = 1'b0;
  logic               in_ready;
  logic               y_valid;
  logic signed [49:0] y_hat;
  logic [9:0]         y_idx;
  logic               busy;
  logic               done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    longint c0;
    longint c1;
    longint c2;
    int     x;
    longint exp;
    int     mode;
  } vec_t;

  vec_t vecs[7];

  poly_eval #(.N_SAMPLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .coef_load (coef_load),
    .b0        (b0),
    .b1        (b1),
    .b2        (b2),
    .in_valid  (in_valid),
    .xi        (xi),
    .in_ready  (in_ready),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .y_hat     (y_hat),
    .y_idx     (y_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint model(input longint c0, input longint c1, input longint c2, input longint x);
    return c0 + c1 * x + c2 * x * x;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_y_valid"}, y_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_y_hat"}, y_hat, 0);
    check({tag, "_y_idx"}, y_idx, 0);
  endtask

  // mode 0: continuous, 1: 5-cycle y_ready stall, 2: gapped input + coef_load mid-run, 3: gapped input and output
  task automatic run_vec(input vec_t v);
    longint             exp_y[$];
    int                 exp_i[$];
    int                 n_acc = 0;
    int                 n_res = 0;
    int                 c = 0;
    bit                 last_taken = 0;
    bit                 finished = 0;
    bit                 prev_stall = 0;
    logic signed [49:0] prev_hat = '0;
    logic [9:0]         prev_idx = '0;
    longint             ey;
    int                 ei;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      coef_load = 1'b0;
      in_valid  = 1'b1;
      xi        = 12'(k * 1000 + 7);
      y_ready   = 1'b1;
      #1;
      check("idle_in_ready", in_ready, 0);
      check("idle_busy", busy, 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    coef_load = 1'b1;
    b0 = 24'(v.c0);
    b1 = 24'(v.c1);
    b2 = 24'(v.c2);
    while (!finished && c < 8000) begin
      @(negedge clk);
      if (c == 0) begin
        check("busy_after_load", busy, 1);
        b0 = ~b0;
        b1 = ~b1;
        b2 = ~b2;
      end
      check("done", done, last_taken);
      if (prev_stall) begin
        check("stall_y_hat", y_hat, prev_hat);
        check("stall_y_idx", y_idx, prev_idx);
        check("stall_y_valid", y_valid, 1);
      end
      if (last_taken) begin
        check("busy_at_done", busy, 0);
        finished = 1;
      end else begin
        coef_load = (v.mode == 2 && c == 50);
        if (coef_load) begin
          b0 = 24'sd77;
          b1 = 24'sd1234;
          b2 = -24'sd999;
        end
        xi       = (n_acc == 0) ? 12'(v.x) : 12'((n_acc * 37 + 5) % 4096);
        in_valid = (v.mode >= 2) ? (c % 5 != 1) : 1'b1;
        y_ready  = (v.mode == 1) ? !(c >= 6 && c < 11) : (v.mode == 3) ? (c % 7 != 3) : 1'b1;
        #1;
        if (y_valid && !y_ready) check("stall_in_ready", in_ready, 0);
        if (n_acc >= N) check("in_ready_after_last", in_ready, 0);
        if (in_valid && in_ready) begin
          exp_y.push_back(model(v.c0, v.c1, v.c2, longint'(xi)));
          exp_i.push_back(n_acc % N);
          n_acc++;
        end
        if (y_valid && y_ready) begin
          if (exp_y.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            ey = exp_y.pop_front();
            ei = exp_i.pop_front();
            check("y_idx", y_idx, ei);
            check("y_hat", y_hat, ey);
            if (n_res == 0) check("table_y_hat", y_hat, v.exp);
            if (n_res == N - 1) last_taken = 1;
            n_res++;
          end
        end
        prev_stall = y_valid && !y_ready;
        prev_hat   = y_hat;
        prev_idx   = y_idx;
      end
      c++;
    end
    check("run_finished", finished, 1);
    check("result_count", n_res, N);
    check("accept_count", n_acc, N);
    in_valid = 1'b1;
    @(negedge clk);
    #1;
    check("done_single_pulse", done, 0);
    check("idle_after_run_in_ready", in_ready, 0);
    check("idle_after_run_y_valid", y_valid, 0);
    in_valid = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{5, -3, 2, 10, 64'sd175, 0};
    vecs[1] = '{0, 0, -8388608, 4095, -64'sd140668777267200, 0};
    vecs[2] = '{8388607, 8388607, 8388607, 4095, 64'sd140703120232447, 1};
    vecs[3] = '{-1, -1, -1, 4095, -64'sd16773121, 2};
    vecs[4] = '{-8388608, -8388608, 0, 4095, -64'sd34359738368, 3};
    vecs[5] = '{1000, 77, -55, 0, 64'sd1000, 3};
    vecs[6] = '{12345, -6789, 100, 2048, 64'sd405538873, 0};

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    @(negedge clk);
    coef_load = 1'b1;
    b0 = 24'sd5;
    b1 = -24'sd3;
    b2 = 24'sd2;
    @(negedge clk);
    coef_load = 1'b0;
    in_valid  = 1'b1;
    xi        = 12'd10;
    y_ready   = 1'b1;
    #1;
    check("basic_in_ready", in_ready, 1);
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check("basic_latency_y_valid", y_valid, (e == 3));
    end
    check("basic_y_hat", y_hat, 175);
    check("basic_y_idx", y_idx, 0);

    n = 1;
    for (int k = 0; k < 400 && n < 300; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      xi       = 12'(k);
      #1;
      if (in_ready) n++;
    end
    check("pre_reset_accepts", n, 300);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    check("busy_before_reset", busy, 1);
    check("y_valid_before_reset", y_valid, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      xi       = 12'(k + 1);
      #1;
      check("post_reset_done", done, 0);
      check("post_reset_busy", busy, 0);
      check("post_reset_in_ready", in_ready, 0);
      check("post_reset_y_valid", y_valid, 0);
    end
    in_valid = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/poly_eval.md
POLY_EVAL -- requirements
Module: poly_eval

Interface
REQ-001 Parameter: N_SAMPLES, default 1024, number of samples evaluated per coefficient set (power of two, 2..1024).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 coef_load  input  1  one-cycle request to latch b0/b1/b2 and start a run.
REQ-005 b0, b1, b2  input  24 each  signed regression coefficients (two's complement).
REQ-006 in_valid  input  1  sample xi present.
REQ-007 xi  input  12  unsigned sample.
REQ-008 in_ready  output  1  block accepts xi this cycle.
REQ-009 y_valid  output  1  y_hat/y_idx hold a result.
REQ-010 y_ready  input  1  downstream accepts the result.
REQ-011 y_hat  output  50  signed result, b0 + b1*xi + b2*xi*xi.
REQ-012 y_idx  output  10  index of the sample within the run, 0-based.
REQ-013 busy  output  1  high in RUN or DRAIN.
REQ-014 done  output  1  one-cycle pulse when the last result of a run is accepted.

Function
REQ-015 The block SHALL use the states IDLE, RUN and DRAIN.
REQ-016 In IDLE with coef_load=1: latch b0/b1/b2, clear the sample counter, go to RUN next cycle.
REQ-017 coef_load in RUN or DRAIN SHALL be ignored; the latched coefficients stay constant for the whole run.
REQ-018 in_ready = (state==RUN) && (accepted count < N_SAMPLES) && pipeline advance; it is never high in IDLE or DRAIN.
REQ-019 A sample is accepted on a cycle with in_valid && in_ready; in_valid without in_ready is ignored and not buffered.
REQ-020 The pipeline SHALL have 3 stages. S1 registers xi, xi*xi (24b unsigned), b1*xi and the index. S2 registers b0 + b1*xi and b2*xi*xi. S3 registers the sum into y_hat.
REQ-021 The pipeline advances when S3 is empty or y_ready=1; on no advance, every stage and y_hat/y_idx/y_valid SHALL hold.
REQ-022 Latency: with y_ready held high, the result appears with y_valid=1 on the 3rd rising edge after acceptance; throughput is 1 sample/cycle.
REQ-023 All arithmetic SHALL be exact, signed, sign-extended to 50 bits, with no truncation, rounding or wrap; xi is zero-extended.
REQ-024 y_idx SHALL equal the acceptance order (0..N_SAMPLES-1) and travel with its sample.
REQ-025 When the N_SAMPLES-th sample is accepted, the state SHALL go RUN->DRAIN on the same edge.
REQ-026 In DRAIN, when the result with y_idx=N_SAMPLES-1 is accepted (y_valid && y_ready), done SHALL pulse for the next cycle, the state returns to IDLE, and busy drops.
REQ-027 A new coef_load is honoured in the cycle after done at the earliest; back-to-back runs are allowed.
REQ-028 An N_SAMPLES=1024 run SHALL use an 11-bit counter internally; y_idx is the low 10 bits.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE; outputs in_ready, y_valid, busy, done = 0; y_hat, y_idx = 0; coefficients, counter and all pipeline valid bits cleared.
REQ-030 Reset mid-run SHALL discard in-flight samples without any done pulse; after release, the block waits in IDLE for coef_load.

Verification
REQ-031 Basic result: b0=5, b1=-3, b2=2, xi=10 accepted, y_ready=1 -> y_hat=175, y_idx=0, y_valid on the 3rd edge after acceptance.
REQ-032 Extreme values: b0=b1=0, b2=-8388608, xi=4095 -> y_hat=-140668777267200 exactly; b2=8388607, b1=8388607, b0=8388607, xi=4095 -> exact positive value per the model, no overflow.
REQ-033 Backpressure: stream 8 samples and hold y_ready=0 for 5 cycles mid-stream -> y_hat/y_idx stable while stalled, in_ready=0, and all results arrive in order with no loss or duplicates.
REQ-034 Full run: N_SAMPLES=1024 with continuous in_valid/y_ready -> exactly 1024 results, y_idx 0..1023, in_ready low after the 1024th acceptance, one done pulse, return to IDLE.
REQ-035 Ignored inputs: coef_load with new coefficients during RUN, and in_valid pulses in IDLE -> results use the original coefficients and no extra samples are counted.
REQ-036 Reset mid-run: assert rst_n=0 after 300 samples -> all outputs 0 at once, no done pulse, and a subsequent run behaves identically to a fresh one.
